// File: rtl/frame_sequencer.sv
// Frame sequencer for an LED matrix: shows one of FRAMES packed frames, chosen
// manually by SEL or auto-rotated by a TICK_DIV prescaler, with hold and blanking.
module frame_sequencer #(
    parameter int ROWS     = 7,
    parameter int COLS     = 5,
    parameter int FRAMES   = 4,
    parameter int TICK_DIV = 50000000,
    localparam int PIX     = ROWS * COLS,
    localparam int IW      = $clog2(FRAMES)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [FRAMES*PIX-1:0] FRAME_IN,
    input  logic [IW-1:0]         SEL,
    input  logic                  MODE,
    input  logic                  HOLD,
    input  logic                  BLANK,
    output logic [PIX-1:0]        FRAME_OUT,
    output logic [IW-1:0]         CUR_IDX,
    output logic                  FRAME_CHG
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [IW:0]   NFR  = (IW+1)'(FRAMES);
    localparam logic [IW-1:0] LAST = IW'(FRAMES - 1);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [IW-1:0]  idx_p0, idx_nxt;
    logic [CW-1:0]  cnt_p0, cnt_nxt;
    logic [PIX-1:0] frame_p0, frame_sel;
    logic           chg_p0;

    // Index/prescaler next state; leaving auto mode falls into the manual branch, which clears cnt.
    always_comb begin
        idx_nxt = idx_p0;
        cnt_nxt = cnt_p0;
        if (!MODE) begin
            cnt_nxt = '0;
            if ({1'b0, SEL} < NFR)
                idx_nxt = SEL;
        end else if (!HOLD) begin
            if (cnt_p0 == TERM) begin
                cnt_nxt = '0;
                idx_nxt = (idx_p0 == LAST) ? '0 : idx_p0 + 1'b1;
            end else begin
                cnt_nxt = cnt_p0 + 1'b1;
            end
        end
    end

    // Output slice follows the next-state index so CUR_IDX and FRAME_OUT move together.
    always_comb begin
        frame_sel = '0;
        for (int f = 0; f < FRAMES; f++)
            if (idx_nxt == IW'(f))
                frame_sel = FRAME_IN[f*PIX +: PIX];
    end

    // Stage p0: architectural state and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_p0   <= '0;
            cnt_p0   <= '0;
            frame_p0 <= '0;
            chg_p0   <= 1'b0;
        end else begin
            idx_p0   <= idx_nxt;
            cnt_p0   <= cnt_nxt;
            frame_p0 <= BLANK ? '0 : frame_sel;
            chg_p0   <= (idx_nxt != idx_p0);
        end
    end

    assign FRAME_OUT = frame_p0;
    assign CUR_IDX   = idx_p0;
    assign FRAME_CHG = chg_p0;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: directed steps queue hand-computed
// expectations; a monitor compares them after every rising edge.
module tb_frame_sequencer;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [139:0]  fin;
    logic [1:0]    sel;
    logic          mode, hold, blank;
    logic [34:0]   fout;
    logic [1:0]    cidx;
    logic          fchg;

    logic [104:0]  fin2;
    logic [1:0]    sel2;
    logic          mode2;
    logic [34:0]   fout2;
    logic [1:0]    cidx2;
    logic          fchg2;

    frame_sequencer #(.ROWS(7), .COLS(5), .FRAMES(4), .TICK_DIV(4)) dut (
        .CLK(CLK), .RST(RST), .FRAME_IN(fin), .SEL(sel), .MODE(mode), .HOLD(hold),
        .BLANK(blank), .FRAME_OUT(fout), .CUR_IDX(cidx), .FRAME_CHG(fchg)
    );

    frame_sequencer #(.ROWS(7), .COLS(5), .FRAMES(3), .TICK_DIV(4)) dut3 (
        .CLK(CLK), .RST(RST), .FRAME_IN(fin2), .SEL(sel2), .MODE(mode2), .HOLD(1'b0),
        .BLANK(1'b0), .FRAME_OUT(fout2), .CUR_IDX(cidx2), .FRAME_CHG(fchg2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          which;
        int          tag;
        logic [34:0] frame;
        logic [1:0]  idx;
        logic        chg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stepno = 0;

    localparam logic [34:0] F0 = 35'h1;
    localparam logic [34:0] F1 = 35'h100;
    localparam logic [34:0] F2 = 35'h10000;
    localparam logic [34:0] F3 = 35'h1000000;
    localparam logic [34:0] N1 = 35'h4_0000_0ABC;
    localparam logic [34:0] N2 = 35'h2_5A5A_5A5A;

    function automatic void chk(string name, int tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, tag, got, exp);
        end
    endfunction

    // Monitor: one expectation per edge, compared just after the edge.
    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.which == 0) begin
                chk("frame_out", e.tag, 64'(fout), 64'(e.frame));
                chk("cur_idx",   e.tag, 64'(cidx), 64'(e.idx));
                chk("frame_chg", e.tag, 64'(fchg), 64'(e.chg));
            end else begin
                chk("frame_out3", e.tag, 64'(fout2), 64'(e.frame));
                chk("cur_idx3",   e.tag, 64'(cidx2), 64'(e.idx));
                chk("frame_chg3", e.tag, 64'(fchg2), 64'(e.chg));
            end
        end
    end

    // Called at a falling edge: drive, queue expectation, cross one rising edge.
    task automatic step(input logic m, input logic h, input logic b, input logic [1:0] s,
                        input logic [34:0] ef, input logic [1:0] ei, input logic ec);
        exp_t e;
        mode = m; hold = h; blank = b; sel = s;
        stepno++;
        e.which = 0; e.tag = stepno; e.frame = ef; e.idx = ei; e.chg = ec;
        q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic step3(input logic [1:0] s, input logic [34:0] ef,
                         input logic [1:0] ei, input logic ec);
        exp_t e;
        mode2 = 1'b0; sel2 = s;
        stepno++;
        e.which = 1; e.tag = stepno; e.frame = ef; e.idx = ei; e.chg = ec;
        q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [1:0] nxt;
        for (int k = 0; k < 4; k++) fin[k*35 +: 35] = 35'h1 << (8*k);
        for (int k = 0; k < 3; k++) fin2[k*35 +: 35] = 35'h1 << (8*k);
        sel = 2'd0; mode = 1'b0; hold = 1'b0; blank = 1'b0;
        sel2 = 2'd0; mode2 = 1'b0;

        // Asynchronous reset before any clock edge
        #1 RST = 1'b1;
        #1;
        chk("rst_frame", 0, 64'(fout), 64'd0);
        chk("rst_idx",   0, 64'(cidx), 64'd0);
        chk("rst_chg",   0, 64'(fchg), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Manual select
        step(0, 0, 0, 2'd0, F0, 2'd0, 0);
        step(0, 0, 0, 2'd2, F2, 2'd2, 1);
        step(0, 0, 0, 2'd2, F2, 2'd2, 0);
        step(0, 0, 0, 2'd2, F2, 2'd2, 0);
        step(0, 0, 0, 2'd0, F0, 2'd0, 1);

        // Auto rotation 0,1,2,3,0 every 4 cycles
        for (int s = 0; s < 4; s++) begin
            nxt = 2'((s + 1) % 4);
            for (int c = 0; c < 3; c++)
                step(1, 0, 0, 2'd0, fin[s*35 +: 35], 2'(s), 0);
            step(1, 0, 0, 2'd0, fin[nxt*35 +: 35], nxt, 1);
        end

        // Hold asserted with cnt at terminal count
        for (int c = 0; c < 3; c++) step(1, 0, 0, 2'd0, F0, 2'd0, 0);
        for (int c = 0; c < 10; c++) step(1, 1, 0, 2'd0, F0, 2'd0, 0);
        step(1, 0, 0, 2'd0, F1, 2'd1, 1);

        // Blank while rotation continues
        for (int c = 0; c < 3; c++) step(1, 0, 1, 2'd0, 35'd0, 2'd1, 0);
        step(1, 0, 1, 2'd0, 35'd0, 2'd2, 1);
        step(1, 0, 0, 2'd0, F2, 2'd2, 0);

        // Data tracking on frame 1, manual then held auto
        step(0, 0, 0, 2'd1, F1, 2'd1, 1);
        fin[35 +: 35] = N1;
        step(0, 0, 0, 2'd1, N1, 2'd1, 0);
        fin[35 +: 35] = N2;
        step(1, 1, 0, 2'd1, N2, 2'd1, 0);

        // Async reset mid-rotation at idx 3
        step(0, 0, 0, 2'd3, F3, 2'd3, 1);
        step(1, 0, 0, 2'd0, F3, 2'd3, 0);
        #2 RST = 1'b1;
        #1;
        chk("arst_frame", stepno, 64'(fout), 64'd0);
        chk("arst_idx",   stepno, 64'(cidx), 64'd0);
        chk("arst_chg",   stepno, 64'(fchg), 64'd0);
        #1 RST = 1'b0;
        for (int c = 0; c < 3; c++) step(1, 0, 0, 2'd0, F0, 2'd0, 0);
        step(1, 0, 0, 2'd0, N2, 2'd1, 1);

        // Illegal select on a three-frame build
        mode = 1'b0;
        step3(2'd1, F1, 2'd1, 1);
        step3(2'd3, F1, 2'd1, 0);
        step3(2'd3, F1, 2'd1, 0);
        step3(2'd2, F2, 2'd2, 1);

        for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge CLK);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
